// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives PC load/stall, runs the I-cache refill
// handshake, squashes IF/ID on redirects, and handles halt and miss timeout.
module fetch_ctrl #(
  parameter int BITS         = 32,
  parameter int BOOT_CYCLES  = 2,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] pc_addr,
  input  logic            ic_hit,
  output logic            ic_fill_req,
  output logic [BITS-1:0] ic_fill_addr,
  input  logic            ic_fill_ack,
  input  logic            redirect,
  input  logic            stall_pipe,
  input  logic            halt,
  output logic            load_instr,
  output logic            cache_stall,
  output logic            if_valid,
  output logic            flush_ifid,
  output logic            halted,
  output logic            miss_timeout,
  output logic [15:0]     miss_count,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_MISS  = 3'd2,
    S_HALT  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(MISS_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;

  assign state_dbg = state;

  // Refill handshake: ic_fill_req is a level held with a stable ic_fill_addr
  // from the miss-detect edge until the edge after the one-cycle ic_fill_ack
  // pulse (or a timeout / reset); acks seen in any other state are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_BOOT;
      cnt          <= '0;
      ic_fill_req  <= 1'b0;
      ic_fill_addr <= '0;
      miss_timeout <= 1'b0;
      miss_count   <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          if (cnt == BOOT_LAST) begin
            state <= S_FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_FETCH: begin
          if (!ic_hit) begin
            state        <= S_MISS;
            ic_fill_req  <= 1'b1;
            ic_fill_addr <= pc_addr;
            cnt          <= '0;
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end else if (!stall_pipe && !redirect && halt) begin
            // a redirect in the same cycle squashes the halt behind it
            state <= S_HALT;
          end
        end
        S_MISS: begin
          if (ic_fill_ack) begin
            state       <= S_FETCH;
            ic_fill_req <= 1'b0;
          end else if (cnt == TMO_LAST) begin
            state        <= S_ERROR;
            miss_timeout <= 1'b1;
            ic_fill_req  <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  always_comb begin
    load_instr  = 1'b0;
    cache_stall = 1'b0;
    if_valid    = 1'b0;
    flush_ifid  = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        load_instr  = ic_hit;
        cache_stall = !ic_hit;
        flush_ifid  = ic_hit && !stall_pipe && redirect;
        if_valid    = ic_hit && !stall_pipe && !redirect && !halt;
      end
      S_MISS:  cache_stall = 1'b1;
      S_HALT: begin
        cache_stall = 1'b1;
        halted      = 1'b1;
      end
      S_ERROR: cache_stall = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, checked each
// cycle against a behavioural model through an expected-value queue.
module tb_fetch_ctrl;
  localparam int BITS         = 32;
  localparam int BOOT_CYCLES  = 2;
  localparam int MISS_TIMEOUT = 8;
  localparam int EW           = BITS + 23;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [BITS-1:0] pc_addr = '0;
  logic            ic_hit = 1'b0;
  logic            ic_fill_ack = 1'b0;
  logic            redirect = 1'b0;
  logic            stall_pipe = 1'b0;
  logic            halt = 1'b0;
  logic            ic_fill_req;
  logic [BITS-1:0] ic_fill_addr;
  logic            load_instr, cache_stall, if_valid, flush_ifid, halted, miss_timeout;
  logic [15:0]     miss_count;
  logic [2:0]      state_dbg;

  fetch_ctrl #(
    .BITS(BITS), .BOOT_CYCLES(BOOT_CYCLES), .MISS_TIMEOUT(MISS_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .ic_hit(ic_hit),
    .ic_fill_req(ic_fill_req), .ic_fill_addr(ic_fill_addr), .ic_fill_ack(ic_fill_ack),
    .redirect(redirect), .stall_pipe(stall_pipe), .halt(halt),
    .load_instr(load_instr), .cache_stall(cache_stall), .if_valid(if_valid),
    .flush_ifid(flush_ifid), .halted(halted), .miss_timeout(miss_timeout),
    .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model of the controller's observable behaviour
  typedef enum {M_BOOT, M_FETCH, M_MISS, M_HALT, M_ERROR} mode_t;
  mode_t           m_mode;
  int              boot_left, miss_age, m_cnt;
  bit              m_req, m_tmo;
  logic [BITS-1:0] m_addr;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    m_mode    = M_BOOT;
    boot_left = BOOT_CYCLES;
    miss_age  = 0;
    m_cnt     = 0;
    m_req     = 1'b0;
    m_tmo     = 1'b0;
    m_addr    = '0;
  endtask

  // driver: apply one cycle of inputs, queue the expected outputs, advance model
  task automatic drive(input bit r, input bit h, input bit a, input bit rd,
                       input bit st, input bit hl, input logic [BITS-1:0] pc);
    bit e_load, e_cstall, e_ifv, e_flush, e_halted;
    @(negedge clk);
    rst = r; ic_hit = h; ic_fill_ack = a; redirect = rd;
    stall_pipe = st; halt = hl; pc_addr = pc;
    e_load   = (m_mode == M_FETCH) && h;
    e_cstall = ((m_mode == M_FETCH) && !h) || (m_mode == M_MISS) ||
               (m_mode == M_HALT) || (m_mode == M_ERROR);
    e_flush  = (m_mode == M_FETCH) && h && !st && rd;
    e_ifv    = (m_mode == M_FETCH) && h && !st && !rd && !hl;
    e_halted = (m_mode == M_HALT);
    exp_q.push_back({e_load, e_cstall, e_ifv, e_flush, e_halted, m_req, m_tmo,
                     m_addr, 16'(m_cnt)});
    if (r) begin
      model_reset();
    end else begin
      case (m_mode)
        M_BOOT: begin
          boot_left--;
          if (boot_left == 0) m_mode = M_FETCH;
        end
        M_FETCH: begin
          if (!h) begin
            m_mode   = M_MISS;
            m_req    = 1'b1;
            m_addr   = pc;
            miss_age = 0;
            if (m_cnt < 65535) m_cnt++;
          end else if (!st && !rd && hl) begin
            m_mode = M_HALT;
          end
        end
        M_MISS: begin
          if (a) begin
            m_mode = M_FETCH;
            m_req  = 1'b0;
          end else begin
            miss_age++;
            if (miss_age == MISS_TIMEOUT) begin
              m_mode = M_ERROR;
              m_tmo  = 1'b1;
              m_req  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, BITS'($urandom));
  endtask

  task automatic do_reset();
    drive(1, 1, 0, 0, 0, 0, '0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // scoreboard monitor: compares every presented output snapshot
  logic [EW-1:0] e;
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("load_instr",   32'(load_instr),   32'(e[BITS+22]));
      chk("cache_stall",  32'(cache_stall),  32'(e[BITS+21]));
      chk("if_valid",     32'(if_valid),     32'(e[BITS+20]));
      chk("flush_ifid",   32'(flush_ifid),   32'(e[BITS+19]));
      chk("halted",       32'(halted),       32'(e[BITS+18]));
      chk("ic_fill_req",  32'(ic_fill_req),  32'(e[BITS+17]));
      chk("miss_timeout", 32'(miss_timeout), 32'(e[BITS+16]));
      chk("ic_fill_addr", 32'(ic_fill_addr), 32'(e[BITS+15:16]));
      chk("miss_count",   32'(miss_count),   32'(e[15:0]));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    model_reset();

    // boot into constant hits
    do_reset();
    idle(6);

    // miss at 0x40, ack in the fifth MISS cycle, then retry hits
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 32'h40);
    drive(0, 0, 1, 0, 0, 0, 32'h40);
    drive(0, 1, 0, 0, 0, 0, 32'h40);
    idle(2);

    // redirect held under a stall, then taken
    drive(0, 1, 0, 1, 1, 0, 32'h44);
    drive(0, 1, 0, 1, 1, 0, 32'h44);
    drive(0, 1, 0, 1, 0, 0, 32'h44);
    idle(1);

    // halt shadowed by redirect, then halt alone; HALT ignores everything
    drive(0, 1, 0, 1, 0, 1, 32'h80);
    drive(0, 1, 0, 0, 0, 1, 32'h84);
    for (int i = 0; i < 20; i++)
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            BITS'($urandom));
    do_reset();
    idle(4);

    // timeout without ack, late ack ignored, reset recovers
    drive(0, 0, 0, 0, 0, 0, 32'h100);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 0, 32'h100);
    drive(0, 1, 1, 0, 0, 0, 32'h100);
    idle(3);
    do_reset();
    drive(0, 1, 1, 0, 0, 0, 32'h0);
    idle(3);

    // ack on the last allowed MISS cycle wins over timeout
    drive(0, 0, 0, 0, 0, 0, 32'h200);
    for (int i = 0; i < MISS_TIMEOUT - 1; i++) drive(0, 0, 0, 0, 0, 0, 32'h200);
    drive(0, 0, 1, 0, 0, 0, 32'h200);
    idle(3);

    // reset in the middle of a refill
    drive(0, 0, 0, 0, 0, 0, 32'h300);
    drive(0, 0, 0, 0, 0, 0, 32'h300);
    do_reset();
    drive(0, 1, 1, 0, 0, 0, 32'h300);
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(99, 0) < 2, $urandom_range(99, 0) < 80,
            $urandom_range(99, 0) < 20, $urandom_range(99, 0) < 15,
            $urandom_range(99, 0) < 20, $urandom_range(99, 0) < 3,
            BITS'($urandom));

    repeat (3) @(negedge clk);
    #4;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
